// File: rtl/l1_pkg.sv
// Shared types and default geometry for the direct-mapped L1 data cache.
// Derived widths follow from the default parameter values of l1_cache.
package l1_pkg;

    localparam int L1_DATA_WIDTH = 32;
    localparam int L1_ADDR_WIDTH = 32;
    localparam int L1_CACHE_SIZE = 256;
    localparam int L1_BLOCK_SIZE = 16;

    localparam int NUM_LINES    = L1_CACHE_SIZE / L1_BLOCK_SIZE;
    localparam int INDEX_WIDTH  = $clog2(NUM_LINES);
    localparam int OFFSET_WIDTH = $clog2(L1_BLOCK_SIZE);
    localparam int TAG_WIDTH    = L1_ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        GAP       = 3'd3,
        ALLOCATE  = 3'd4
    } state_t;

    // One cache line at the default geometry.
    typedef struct packed {
        logic [TAG_WIDTH-1:0]                       tag;
        logic                                       valid;
        logic                                       dirty;
        logic [L1_BLOCK_SIZE*L1_DATA_WIDTH-1:0]     data;
    } line_t;

endpackage

// File: rtl/l1_line_store.sv
// Tag/valid/dirty/data arrays: one asynchronous read port by index and one
// write port that either installs a full line or updates a single word.
module l1_line_store #(
    parameter int DATA_WIDTH   = 32,
    parameter int BLOCK_SIZE   = 16,
    parameter int NUM_LINES    = 16,
    parameter int TAG_WIDTH    = 24,
    parameter int INDEX_WIDTH  = $clog2(NUM_LINES),
    parameter int OFFSET_WIDTH = $clog2(BLOCK_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INDEX_WIDTH-1:0]         i_rd_index,
    output logic [TAG_WIDTH-1:0]           o_rd_tag,
    output logic                           o_rd_valid,
    output logic                           o_rd_dirty,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] o_rd_line,
    input  logic                           i_we_line,
    input  logic                           i_we_word,
    input  logic [INDEX_WIDTH-1:0]         i_wr_index,
    input  logic [OFFSET_WIDTH-1:0]        i_wr_offset,
    input  logic [TAG_WIDTH-1:0]           i_wr_tag,
    input  logic                           i_wr_dirty,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] i_wr_line,
    input  logic [DATA_WIDTH-1:0]          i_wr_word
);

    localparam int LINE_W = BLOCK_SIZE * DATA_WIDTH;

    logic [TAG_WIDTH-1:0] r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_dirty = r_dirty[i_rd_index];
    assign o_rd_line  = r_data[i_rd_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we_line) begin
            r_valid[i_wr_index] <= 1'b1;
            r_dirty[i_wr_index] <= i_wr_dirty;
        end else if (i_we_word) begin
            r_dirty[i_wr_index] <= 1'b1;
        end
    end

    // Tags and data keep their contents across reset; only valid/dirty clear.
    always_ff @(posedge clk) begin
        if (i_we_line) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_line;
        end else if (i_we_word) begin
            r_data[i_wr_index][int'(i_wr_offset)*DATA_WIDTH +: DATA_WIDTH] <= i_wr_word;
        end
    end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache. Word-granular CPU
// port; whole-line transfers to L2 with a request/ready handshake.
module l1_cache
    import l1_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CACHE_SIZE = 256,
    parameter int BLOCK_SIZE = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [DATA_WIDTH-1:0]            cpu_data_in,
    input  logic                             cpu_read,
    input  logic                             cpu_write,
    output logic [DATA_WIDTH-1:0]            cpu_data_out,
    output logic                             cpu_ready,
    output logic                             l1_hit,
    output logic [ADDR_WIDTH-1:0]            l2_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_in,
    output logic                             l2_read,
    output logic                             l2_write,
    input  logic                             l2_ready,
    output logic [CNT_WIDTH-1:0]             hit_count,
    output logic [CNT_WIDTH-1:0]             miss_count,
    output logic [2:0]                       dbg_state
);

    localparam int LINES  = CACHE_SIZE / BLOCK_SIZE;
    localparam int IW     = $clog2(LINES);
    localparam int OW     = $clog2(BLOCK_SIZE);
    localparam int TW     = ADDR_WIDTH - IW - OW;
    localparam int LINE_W = BLOCK_SIZE * DATA_WIDTH;

    // L2 handshake: l2_read/l2_write is a held request; the transfer completes
    // on the first rising edge where l2_ready is sampled high while the request
    // is up. The request drops on that same edge and l2_ready is ignored otherwise.

    state_t                r_state, w_state_n;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_n;
    logic                  r_is_write, w_is_write_n;

    logic [DATA_WIDTH-1:0] r_cpu_data_out, w_cpu_data_out_n;
    logic                  r_cpu_ready, w_cpu_ready_n;
    logic                  r_l1_hit, w_l1_hit_n;
    logic [ADDR_WIDTH-1:0] r_l2_addr, w_l2_addr_n;
    logic [LINE_W-1:0]     r_l2_data_out, w_l2_data_out_n;
    logic                  r_l2_read, w_l2_read_n;
    logic                  r_l2_write, w_l2_write_n;
    logic [CNT_WIDTH-1:0]  r_hit_count, w_hit_count_n;
    logic [CNT_WIDTH-1:0]  r_miss_count, w_miss_count_n;

    logic [OW-1:0]         w_offset;
    logic [IW-1:0]         w_index;
    logic [TW-1:0]         w_tag;
    logic [TW-1:0]         w_rd_tag;
    logic                  w_rd_valid;
    logic                  w_rd_dirty;
    logic [LINE_W-1:0]     w_rd_line;
    logic                  w_hit;
    logic                  w_we_line;
    logic                  w_we_word;
    logic [LINE_W-1:0]     w_fill_line;

    assign w_offset = r_addr[OW-1:0];
    assign w_index  = r_addr[OW +: IW];
    assign w_tag    = r_addr[ADDR_WIDTH-1 -: TW];
    assign w_hit    = w_rd_valid && (w_rd_tag == w_tag);

    l1_line_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_LINES  (LINES),
        .TAG_WIDTH  (TW),
        .INDEX_WIDTH(IW),
        .OFFSET_WIDTH(OW)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .i_rd_index (w_index),
        .o_rd_tag   (w_rd_tag),
        .o_rd_valid (w_rd_valid),
        .o_rd_dirty (w_rd_dirty),
        .o_rd_line  (w_rd_line),
        .i_we_line  (w_we_line && !rst),
        .i_we_word  (w_we_word && !rst),
        .i_wr_index (w_index),
        .i_wr_offset(w_offset),
        .i_wr_tag   (w_tag),
        .i_wr_dirty (r_is_write),
        .i_wr_line  (w_fill_line),
        .i_wr_word  (r_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_is_write     <= 1'b0;
            r_cpu_data_out <= '0;
            r_cpu_ready    <= 1'b0;
            r_l1_hit       <= 1'b0;
            r_l2_addr      <= '0;
            r_l2_data_out  <= '0;
            r_l2_read      <= 1'b0;
            r_l2_write     <= 1'b0;
            r_hit_count    <= '0;
            r_miss_count   <= '0;
        end else begin
            r_state        <= w_state_n;
            r_addr         <= w_addr_n;
            r_wdata        <= w_wdata_n;
            r_is_write     <= w_is_write_n;
            r_cpu_data_out <= w_cpu_data_out_n;
            r_cpu_ready    <= w_cpu_ready_n;
            r_l1_hit       <= w_l1_hit_n;
            r_l2_addr      <= w_l2_addr_n;
            r_l2_data_out  <= w_l2_data_out_n;
            r_l2_read      <= w_l2_read_n;
            r_l2_write     <= w_l2_write_n;
            r_hit_count    <= w_hit_count_n;
            r_miss_count   <= w_miss_count_n;
        end
    end

    always_comb begin
        w_state_n        = r_state;
        w_addr_n         = r_addr;
        w_wdata_n        = r_wdata;
        w_is_write_n     = r_is_write;
        w_cpu_data_out_n = r_cpu_data_out;
        w_cpu_ready_n    = 1'b0;
        w_l1_hit_n       = 1'b0;
        w_l2_addr_n      = r_l2_addr;
        w_l2_data_out_n  = r_l2_data_out;
        w_l2_read_n      = r_l2_read;
        w_l2_write_n     = r_l2_write;
        w_hit_count_n    = r_hit_count;
        w_miss_count_n   = r_miss_count;
        w_we_line        = 1'b0;
        w_we_word        = 1'b0;
        // A store miss installs the fill with the stored word already merged in.
        w_fill_line      = l2_data_in;
        if (r_is_write)
            w_fill_line[int'(w_offset)*DATA_WIDTH +: DATA_WIDTH] = r_wdata;

        case (r_state)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    w_addr_n     = cpu_addr;
                    w_wdata_n    = cpu_data_in;
                    w_is_write_n = cpu_write;
                    w_state_n    = COMPARE;
                end
            end
            COMPARE: begin
                if (w_hit) begin
                    if (r_is_write)
                        w_we_word = 1'b1;
                    else
                        w_cpu_data_out_n = w_rd_line[int'(w_offset)*DATA_WIDTH +: DATA_WIDTH];
                    w_cpu_ready_n = 1'b1;
                    w_l1_hit_n    = 1'b1;
                    w_hit_count_n = r_hit_count + CNT_WIDTH'(1);
                    w_state_n     = IDLE;
                end else begin
                    w_miss_count_n = r_miss_count + CNT_WIDTH'(1);
                    if (w_rd_valid && w_rd_dirty) begin
                        w_l2_addr_n     = {w_rd_tag, w_index, {OW{1'b0}}};
                        w_l2_data_out_n = w_rd_line;
                        w_l2_write_n    = 1'b1;
                        w_state_n       = WRITEBACK;
                    end else begin
                        w_l2_addr_n  = {w_tag, w_index, {OW{1'b0}}};
                        w_l2_read_n  = 1'b1;
                        w_state_n    = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                if (l2_ready) begin
                    w_l2_write_n = 1'b0;
                    w_state_n    = GAP;
                end
            end
            GAP: begin
                w_l2_addr_n = {w_tag, w_index, {OW{1'b0}}};
                w_l2_read_n = 1'b1;
                w_state_n   = ALLOCATE;
            end
            ALLOCATE: begin
                if (l2_ready) begin
                    w_we_line = 1'b1;
                    if (!r_is_write)
                        w_cpu_data_out_n = l2_data_in[int'(w_offset)*DATA_WIDTH +: DATA_WIDTH];
                    w_l2_read_n   = 1'b0;
                    w_cpu_ready_n = 1'b1;
                    w_l1_hit_n    = 1'b0;
                    w_state_n     = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign cpu_data_out = r_cpu_data_out;
    assign cpu_ready    = r_cpu_ready;
    assign l1_hit       = r_l1_hit;
    assign l2_addr      = r_l2_addr;
    assign l2_data_out  = r_l2_data_out;
    assign l2_read      = r_l2_read;
    assign l2_write     = r_l2_write;
    assign hit_count    = r_hit_count;
    assign miss_count   = r_miss_count;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache: behavioural L2 answering after 3 cycles,
// hand-computed expectations, one checking task and a final summary line.
module tb_l1_cache;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 16;
    localparam int CW = 16;
    localparam int LW = BS * DW;
    localparam int BUDGET = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data_in;
    logic          cpu_read;
    logic          cpu_write;
    logic [DW-1:0] cpu_data_out;
    logic          cpu_ready;
    logic          l1_hit;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_data_out;
    logic [LW-1:0] l2_data_in;
    logic          l2_read;
    logic          l2_write;
    logic          l2_ready;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    logic saw_write    = 1'b0;
    logic saw_both     = 1'b0;
    logic saw_misalign = 1'b0;
    int   l2_cnt       = 0;

    always #5 clk = ~clk;

    l1_cache dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_data_in (cpu_data_in),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_data_out(cpu_data_out),
        .cpu_ready   (cpu_ready),
        .l1_hit      (l1_hit),
        .l2_addr     (l2_addr),
        .l2_data_out (l2_data_out),
        .l2_data_in  (l2_data_in),
        .l2_read     (l2_read),
        .l2_write    (l2_write),
        .l2_ready    (l2_ready),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .dbg_state   (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // L2 model: counts request cycles, raises ready for one cycle on the third.
    initial begin
        l2_ready   = 1'b0;
        l2_data_in = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                l2_ready = 1'b0;
                l2_cnt   = 0;
            end else if (l2_ready) begin
                l2_ready = 1'b0;
            end else if (l2_read || l2_write) begin
                l2_cnt++;
                if (l2_cnt == 3) begin
                    l2_cnt   = 0;
                    l2_ready = 1'b1;
                    for (int i = 0; i < BS; i++)
                        l2_data_in[i*DW +: DW] = (l2_addr == 32'h110) ? 32'(32'hB000_0000 + i)
                                                                      : 32'(32'hA000_0000 + i);
                end
            end
            if (l2_write) saw_write = 1'b1;
            if (l2_read && l2_write) saw_both = 1'b1;
            if ((l2_read || l2_write) && (l2_addr[3:0] != 4'h0)) saw_misalign = 1'b1;
        end
    end

    // Present a request for one cycle; returns at the negedge with the DUT in COMPARE.
    task automatic start_op(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic rd, input logic wr);
        @(negedge clk);
        cpu_addr    = addr;
        cpu_data_in = data;
        cpu_read    = rd;
        cpu_write   = wr;
        @(posedge clk);
        @(negedge clk);
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!cpu_ready && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check_eq(tag, LW'(cpu_ready), LW'(1));
    endtask

    task automatic wait_l2_read(input string tag);
        int cyc = 0;
        while (!l2_read && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check_eq(tag, LW'(l2_read), LW'(1));
    endtask

    task automatic check_read_data(input string tag);
        logic [DW-1:0] exp;
        exp = exp_q.pop_front();
        check_eq(tag, LW'(cpu_data_out), LW'(exp));
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        cpu_addr = '0; cpu_data_in = '0; cpu_read = 1'b0; cpu_write = 1'b0;

        // 1. reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_data_out", LW'(cpu_data_out), '0);
        check_eq("rst_ready",    LW'(cpu_ready), '0);
        check_eq("rst_hit",      LW'(l1_hit), '0);
        check_eq("rst_l2_addr",  LW'(l2_addr), '0);
        check_eq("rst_l2_dout",  l2_data_out, '0);
        check_eq("rst_l2_read",  LW'(l2_read), '0);
        check_eq("rst_l2_write", LW'(l2_write), '0);
        check_eq("rst_hits",     LW'(hit_count), '0);
        check_eq("rst_misses",   LW'(miss_count), '0);
        check_eq("rst_state",    LW'(dbg_state), '0);
        rst = 1'b0;

        // 2. cold read miss
        exp_q.push_back(32'hA000_0003);
        start_op(32'h13, '0, 1'b1, 1'b0);
        wait_l2_read("cold_l2_read");
        check_eq("cold_l2_addr", LW'(l2_addr), LW'(32'h10));
        wait_ready("cold_ready");
        check_read_data("cold_data");
        check_eq("cold_hit",    LW'(l1_hit), '0);
        check_eq("cold_misses", LW'(miss_count), LW'(1));
        check_eq("cold_hits",   LW'(hit_count), '0);
        @(negedge clk);
        check_eq("cold_ready_pulse", LW'(cpu_ready), '0);

        // 3. read hit with fixed 2-cycle latency
        exp_q.push_back(32'hA000_0002);
        start_op(32'h12, '0, 1'b1, 1'b0);
        check_eq("hit_ready_early", LW'(cpu_ready), '0);
        @(negedge clk);
        check_eq("hit_ready_2cyc", LW'(cpu_ready), LW'(1));
        check_read_data("hit_data");
        check_eq("hit_flag",    LW'(l1_hit), LW'(1));
        check_eq("hit_l2_read", LW'(l2_read), '0);
        check_eq("hit_hits",    LW'(hit_count), LW'(1));

        // 4. write hit dirties the line; conflicting read forces writeback
        start_op(32'h15, 32'hDEAD_BEEF, 1'b0, 1'b1);
        wait_ready("wr_hit_ready");
        check_eq("wr_hit_flag", LW'(l1_hit), LW'(1));
        check_eq("wr_hit_hits", LW'(hit_count), LW'(2));
        exp_q.push_back(32'hB000_0005);
        start_op(32'h115, '0, 1'b1, 1'b0);
        cyc = 0;
        while (!l2_write && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("wb_l2_write", LW'(l2_write), LW'(1));
        check_eq("wb_l2_addr",  LW'(l2_addr), LW'(32'h10));
        check_eq("wb_word5",    LW'(l2_data_out[5*DW +: DW]), LW'(32'hDEAD_BEEF));
        check_eq("wb_word0",    LW'(l2_data_out[0 +: DW]), LW'(32'hA000_0000));
        check_eq("wb_word15",   LW'(l2_data_out[15*DW +: DW]), LW'(32'hA000_000F));
        check_eq("wb_no_read",  LW'(l2_read), '0);
        cyc = 0;
        while (l2_write && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("gap_write_low", LW'(l2_write), '0);
        check_eq("gap_read_low",  LW'(l2_read), '0);
        @(negedge clk);
        check_eq("alloc_read",    LW'(l2_read), LW'(1));
        check_eq("alloc_addr",    LW'(l2_addr), LW'(32'h110));
        wait_ready("wb_ready");
        check_read_data("wb_data");
        check_eq("wb_hit",    LW'(l1_hit), '0);
        check_eq("wb_misses", LW'(miss_count), LW'(2));

        // 5. write miss to an invalid line: no writeback, merged fill
        @(negedge clk);
        saw_write = 1'b0;
        start_op(32'h2025, 32'h1234, 1'b0, 1'b1);
        wait_l2_read("wmiss_l2_read");
        check_eq("wmiss_l2_addr", LW'(l2_addr), LW'(32'h2020));
        wait_ready("wmiss_ready");
        check_eq("wmiss_hit",   LW'(l1_hit), '0);
        check_eq("wmiss_no_wb", LW'(saw_write), '0);
        exp_q.push_back(32'h0000_1234);
        start_op(32'h2025, '0, 1'b1, 1'b0);
        wait_ready("wmiss_rd_ready");
        check_read_data("wmiss_rd_data");
        check_eq("wmiss_rd_hit", LW'(l1_hit), LW'(1));
        check_eq("wmiss_hits",   LW'(hit_count), LW'(3));
        check_eq("wmiss_misses", LW'(miss_count), LW'(3));

        // 6. reset during ALLOCATE, then combined read+write treated as write
        start_op(32'h33, '0, 1'b1, 1'b0);
        wait_l2_read("abort_l2_read");
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_l2_read_low", LW'(l2_read), '0);
        check_eq("abort_l2_write",    LW'(l2_write), '0);
        check_eq("abort_hits",        LW'(hit_count), '0);
        check_eq("abort_misses",      LW'(miss_count), '0);
        check_eq("abort_ready",       LW'(cpu_ready), '0);
        rst = 1'b0;
        exp_q.push_back(32'hA000_0003);
        start_op(32'h13, '0, 1'b1, 1'b0);
        wait_l2_read("post_rst_miss");
        wait_ready("post_rst_ready");
        check_read_data("post_rst_data");
        check_eq("post_rst_hit",    LW'(l1_hit), '0);
        check_eq("post_rst_misses", LW'(miss_count), LW'(1));
        start_op(32'h13, 32'h5, 1'b1, 1'b1);
        wait_ready("both_ready");
        check_eq("both_hit", LW'(l1_hit), LW'(1));
        exp_q.push_back(32'h0000_0005);
        start_op(32'h13, '0, 1'b1, 1'b0);
        wait_ready("both_rd_ready");
        check_read_data("both_rd_data");
        check_eq("both_hits", LW'(hit_count), LW'(2));

        // Signal rules observed throughout the run
        check_eq("rule_rd_wr_excl", LW'(saw_both), '0);
        check_eq("rule_aligned",    LW'(saw_misalign), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l1_cache.md
Name: l1_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the CPU load/store port and L2_cache, and is the direct upstream requester of L2.
- CPU side is word-granular. L2 side moves whole L1 blocks with a request/ready handshake.
- Keeps hit and miss counters for performance runs.

Parameters:
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 32, word-address width
- CACHE_SIZE, 256, total capacity in words
- BLOCK_SIZE, 16, words per line; must equal the L1_BLOCK_SIZE seen by L2
- CNT_WIDTH, 16, width of the hit and miss counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_data_in  in  DATA_WIDTH  store data
- cpu_read  in  1  load request
- cpu_write  in  1  store request
- cpu_data_out  out  DATA_WIDTH  load data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- l1_hit  out  1  high together with cpu_ready when the access hit
- l2_addr  out  ADDR_WIDTH  block-aligned address
- l2_data_out  out  BLOCK_SIZE×DATA_WIDTH  writeback block
- l2_data_in  in  BLOCK_SIZE×DATA_WIDTH  fill block
- l2_read  out  1  fill request
- l2_write  out  1  writeback request
- l2_ready  in  1  L2 completion
- hit_count  out  CNT_WIDTH  wrapping hit counter
- miss_count  out  CNT_WIDTH  wrapping miss counter

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Address split: offset = addr[log2(BLOCK_SIZE)-1:0]; index = next log2(CACHE_SIZE/BLOCK_SIZE) bits; tag = remaining upper bits.
- Reset: state IDLE; all valid and dirty bits cleared; every output 0, counters included.
- Reset asserted mid-operation aborts any in-flight L2 transaction. l2_read and l2_write are low from the next cycle; data arrays are not cleared.
- IDLE:
  - cpu_ready=0, l1_hit=0.
  - If cpu_read or cpu_write is high: latch addr, data and op, then go to COMPARE.
  - Both high: treated as a write.
  - Requests are accepted only in IDLE. The CPU drops its request in the cpu_ready cycle; a request still held there is accepted as a new access.
- COMPARE (1 cycle), hit (line valid and tag match):
  - Read: cpu_data_out <= line[offset].
  - Write: line[offset] <= data, dirty <= 1.
  - cpu_ready <= 1, l1_hit <= 1, hit_count++, then IDLE.
- COMPARE, miss:
  - miss_count++.
  - Victim valid and dirty: l2_addr <= {victim_tag, index, 0}, l2_data_out <= line, l2_write <= 1, go to WRITEBACK.
  - Otherwise: l2_addr <= {tag, index, 0}, l2_read <= 1, go to ALLOCATE.
- WRITEBACK:
  - Hold l2_write, l2_addr and l2_data_out until l2_ready is sampled high.
  - On that edge: l2_write <= 0, then go to GAP.
- GAP (1 cycle, lets L2 drop ready): l2_addr <= {tag, index, 0}, l2_read <= 1, go to ALLOCATE.
- ALLOCATE:
  - Hold l2_read until l2_ready is sampled high.
  - On that edge:
    - Install l2_data_in, set tag, valid=1.
    - Read: dirty=0, cpu_data_out <= l2_data_in[offset].
    - Write: merge the word, dirty=1.
    - l2_read <= 0, cpu_ready <= 1, l1_hit <= 0, then IDLE.
- Latency:
  - Hit: cpu_ready high 2 cycles after the request is sampled.
  - Clean miss: 2 cycles + L2 time.
  - Dirty miss: adds writeback + 1 gap cycle.
- Signal rules:
  - l2_read and l2_write are never high together.
  - l2_addr low offset bits are always 0.
  - l2_ready seen in IDLE, COMPARE or GAP is ignored.
- Counters wrap at 2^CNT_WIDTH.

Decomposition:
- l1_pkg holds:
  - state enum: IDLE, COMPARE, WRITEBACK, GAP, ALLOCATE;
  - derived constants: NUM_LINES, INDEX_WIDTH, OFFSET_WIDTH, TAG_WIDTH;
  - a line-struct typedef (tag, valid, dirty, data).
- One natural sub-module, l1_line_store: tag/valid/dirty/data arrays with one read port (async, by index) and one write port (full line or single word). Valid and dirty clear on rst.

Test Plan (defaults: index = addr[7:4], tag = addr[31:8]; L2 model returns word i = 0xA000_0000+i, for fill address 0x110 word i = 0xB000_0000+i, ready after 3 cycles):
1. Hold rst 2 cycles → all outputs 0; read 0x13 then misses.
2. Cold read 0x13 → l2_read=1 with l2_addr=0x10; after ready: cpu_data_out=0xA000_0003, cpu_ready pulse, l1_hit=0, miss_count=1.
3. Read 0x12 → cpu_ready exactly 2 cycles after the request; data 0xA000_0002; l2_read stays 0; l1_hit=1; hit_count=1.
4. Write 0x15 ← 0xDEAD_BEEF (hit), then read 0x115:
   - l2_write with l2_addr=0x10 and l2_data_out[5]=0xDEAD_BEEF, other words 0xA000_000i;
   - after ack, one gap cycle, then l2_read with l2_addr=0x110;
   - result 0xB000_0005.
5. Write miss 0x2025 ← 0x1234 to a clean/invalid line → no l2_write; l2_read 0x2020; then read 0x2025 hits with 0x1234.
6. Assert rst while l2_read is high in ALLOCATE → l2_read=0 next cycle, counters 0; a later read 0x13 misses. Then drive cpu_read and cpu_write together to 0x13 ← 0x5 → handled as a write; a read of 0x13 then returns 0x5.
